// File: rtl/commit_lockstep_checker.sv
// commit_lockstep_checker: lockstep compare of DUT vs reference commit records through per-side FIFOs
// Ports: clk, rst (async active-high), clear (sync flush); dut_*/ref_* commit records with
// valid/ready handshakes; cmp_valid/mismatch/mismatch_code/mismatch_pc result pulse; halted;
// saturating match_cnt/err_cnt.
module commit_lockstep_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full
);
  localparam int AB = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AB:0] wp, rp;
  assign empty = wp == rp;
  assign full = wp == {~rp[AB], rp[AB-1:0]};
  assign dout = mem[rp[AB-1:0]];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else if (clear) begin
      wp <= '0;
      rp <= '0;
    end else begin
      wp <= wp + (AB+1)'(push);
      rp <= rp + (AB+1)'(pop);
    end
  always_ff @(posedge clk)
    if (push) mem[wp[AB-1:0]] <= din;
endmodule

module commit_lockstep_checker #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int DEPTH = 4,
  parameter int TIMEOUT = 64,
  parameter bit HALT_ON_ERR = 1,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              dut_valid,
  output logic              dut_ready,
  input  logic [AW-1:0]     dut_pc,
  input  logic              dut_rf_we,
  input  logic [4:0]        dut_rf_addr,
  input  logic [DW-1:0]     dut_rf_data,
  input  logic              dut_st_en,
  input  logic [AW-1:0]     dut_st_addr,
  input  logic [DW/8-1:0]   dut_st_be,
  input  logic [DW-1:0]     dut_st_data,
  input  logic              ref_valid,
  output logic              ref_ready,
  input  logic [AW-1:0]     ref_pc,
  input  logic              ref_rf_we,
  input  logic [4:0]        ref_rf_addr,
  input  logic [DW-1:0]     ref_rf_data,
  input  logic              ref_st_en,
  input  logic [AW-1:0]     ref_st_addr,
  input  logic [DW/8-1:0]   ref_st_be,
  input  logic [DW-1:0]     ref_st_data,
  output logic              cmp_valid,
  output logic              mismatch,
  output logic [4:0]        mismatch_code,
  output logic [AW-1:0]     mismatch_pc,
  output logic              halted,
  output logic [CNT_W-1:0]  match_cnt,
  output logic [CNT_W-1:0]  err_cnt
);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef struct packed {
    logic [AW-1:0]   pc;
    logic            rf_we;
    logic [4:0]      rf_addr;
    logic [DW-1:0]   rf_data;
    logic            st_en;
    logic [AW-1:0]   st_addr;
    logic [DW/8-1:0] st_be;
    logic [DW-1:0]   st_data;
  } rec_t;
  typedef enum logic {RUN, HALT} state_t;
  state_t state, state_d;
  rec_t d_in, r_in, d, r;
  logic d_empty, d_full, r_empty, r_full, d_push, r_push, run, do_cmp, tmo, res_valid, res_err;
  logic d_we, r_we, both_st;
  logic [DW-1:0] mask;
  logic [4:0] cmp_code, res_code;
  logic [TW-1:0] timer;
  assign d_in = '{dut_pc, dut_rf_we, dut_rf_addr, dut_rf_data, dut_st_en, dut_st_addr, dut_st_be, dut_st_data};
  assign r_in = '{ref_pc, ref_rf_we, ref_rf_addr, ref_rf_data, ref_st_en, ref_st_addr, ref_st_be, ref_st_data};
  assign halted = state == HALT;
  assign run = state == RUN;
  // ready is held low during reset so every output reads 0 while rst is asserted
  assign dut_ready = !d_full & !halted & !rst;
  assign ref_ready = !r_full & !halted & !rst;
  assign d_push = dut_valid & dut_ready & !clear;
  assign r_push = ref_valid & ref_ready & !clear;
  assign do_cmp = run & !d_empty & !r_empty;
  assign tmo = run & (d_empty ^ r_empty) & (timer == TW'(TIMEOUT - 1));
  assign res_valid = do_cmp | tmo;
  assign res_code = do_cmp ? cmp_code : 5'b10000;
  assign res_err = |res_code;
  commit_lockstep_fifo #(.W($bits(rec_t)), .DEPTH(DEPTH)) u_dfifo (
    .clk(clk), .rst(rst), .clear(clear), .push(d_push), .pop(do_cmp & !clear),
    .din(d_in), .dout(d), .empty(d_empty), .full(d_full)
  );
  commit_lockstep_fifo #(.W($bits(rec_t)), .DEPTH(DEPTH)) u_rfifo (
    .clk(clk), .rst(rst), .clear(clear), .push(r_push), .pop(do_cmp & !clear),
    .din(r_in), .dout(r), .empty(r_empty), .full(r_full)
  );
  always_comb begin
    d_we = d.rf_we & (d.rf_addr != '0);
    r_we = r.rf_we & (r.rf_addr != '0);
    both_st = d.st_en & r.st_en;
    mask = '0;
    for (int i = 0; i < DW/8; i++) mask[i*8 +: 8] = {8{d.st_be[i]}};
    cmp_code = {1'b0,
                both_st & |((d.st_data ^ r.st_data) & mask),
                (d.st_en != r.st_en) | (both_st & ((d.st_addr != r.st_addr) | (d.st_be != r.st_be))),
                (d_we != r_we) | (d_we & r_we & ((d.rf_addr != r.rf_addr) | (d.rf_data != r.rf_data))),
                d.pc != r.pc};
  end
  always_comb begin
    state_d = state;
    if (clear) state_d = RUN;
    else if (run & res_valid & res_err & HALT_ON_ERR) state_d = HALT;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= RUN;
    else state <= state_d;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cmp_valid <= 1'b0;
      mismatch <= 1'b0;
      mismatch_code <= '0;
      mismatch_pc <= '0;
      match_cnt <= '0;
      err_cnt <= '0;
      timer <= '0;
    end else if (clear) begin
      cmp_valid <= 1'b0;
      mismatch <= 1'b0;
      mismatch_code <= '0;
      match_cnt <= '0;
      err_cnt <= '0;
      timer <= '0;
    end else begin
      cmp_valid <= res_valid;
      mismatch <= res_valid & res_err;
      if (run) timer <= (do_cmp | tmo | (d_empty == r_empty)) ? '0 : timer + TW'(1);
      if (res_valid) mismatch_code <= res_code;
      // on a timeout with the DUT side empty, the only PC available is the reference head
      if (res_valid & res_err) mismatch_pc <= (tmo & d_empty) ? r.pc : d.pc;
      if (res_valid & !res_err) match_cnt <= match_cnt + CNT_W'(match_cnt != '1);
      if (res_valid & res_err) err_cnt <= err_cnt + CNT_W'(err_cnt != '1);
    end
endmodule

// File: tb/tb_commit_lockstep_checker.sv
// tb_commit_lockstep_checker: directed and randomized checks of commit_lockstep_checker
module tb_commit_lockstep_checker;
  localparam int TMO = 64;
  localparam int N = 40;
  typedef struct packed {
    logic [31:0] pc;
    logic        rf_we;
    logic [4:0]  rf_addr;
    logic [31:0] rf_data;
    logic        st_en;
    logic [31:0] st_addr;
    logic [3:0]  st_be;
    logic [31:0] st_data;
  } rec_t;
  logic clk = 0, rst = 0, clear = 0, dv = 0, rv = 0;
  rec_t dr = '0, rr = '0;
  logic a_dready, a_rready, a_cv, a_mm, a_halt, b_dready, b_rready, b_cv, b_mm, b_halt;
  logic [4:0] a_code, b_code;
  logic [31:0] a_mpc, b_mpc;
  logic [15:0] a_mc, a_ec, b_mc, b_ec;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  commit_lockstep_checker #(.TIMEOUT(TMO), .HALT_ON_ERR(1)) u_a (
    .clk(clk), .rst(rst), .clear(clear),
    .dut_valid(dv), .dut_ready(a_dready), .dut_pc(dr.pc), .dut_rf_we(dr.rf_we), .dut_rf_addr(dr.rf_addr),
    .dut_rf_data(dr.rf_data), .dut_st_en(dr.st_en), .dut_st_addr(dr.st_addr), .dut_st_be(dr.st_be),
    .dut_st_data(dr.st_data),
    .ref_valid(rv), .ref_ready(a_rready), .ref_pc(rr.pc), .ref_rf_we(rr.rf_we), .ref_rf_addr(rr.rf_addr),
    .ref_rf_data(rr.rf_data), .ref_st_en(rr.st_en), .ref_st_addr(rr.st_addr), .ref_st_be(rr.st_be),
    .ref_st_data(rr.st_data),
    .cmp_valid(a_cv), .mismatch(a_mm), .mismatch_code(a_code), .mismatch_pc(a_mpc), .halted(a_halt),
    .match_cnt(a_mc), .err_cnt(a_ec)
  );
  commit_lockstep_checker #(.TIMEOUT(TMO), .HALT_ON_ERR(0)) u_b (
    .clk(clk), .rst(rst), .clear(clear),
    .dut_valid(dv), .dut_ready(b_dready), .dut_pc(dr.pc), .dut_rf_we(dr.rf_we), .dut_rf_addr(dr.rf_addr),
    .dut_rf_data(dr.rf_data), .dut_st_en(dr.st_en), .dut_st_addr(dr.st_addr), .dut_st_be(dr.st_be),
    .dut_st_data(dr.st_data),
    .ref_valid(rv), .ref_ready(b_rready), .ref_pc(rr.pc), .ref_rf_we(rr.rf_we), .ref_rf_addr(rr.rf_addr),
    .ref_rf_data(rr.rf_data), .ref_st_en(rr.st_en), .ref_st_addr(rr.st_addr), .ref_st_be(rr.st_be),
    .ref_st_data(rr.st_data),
    .cmp_valid(b_cv), .mismatch(b_mm), .mismatch_code(b_code), .mismatch_pc(b_mpc), .halted(b_halt),
    .match_cnt(b_mc), .err_cnt(b_ec)
  );
  function automatic rec_t rand_rec();
    rec_t x;
    x.pc = $urandom & 32'hFFFF_FFFC;
    x.rf_we = 1'($urandom);
    x.rf_addr = 5'($urandom);
    x.rf_data = $urandom;
    x.st_en = 1'($urandom);
    x.st_addr = $urandom;
    x.st_be = 4'($urandom);
    x.st_data = $urandom;
    return x;
  endfunction
  function automatic logic [4:0] exp_code(rec_t d, rec_t r);
    logic [4:0] c = 5'b0;
    bit dwe = d.rf_we && d.rf_addr != 0;
    bit rwe = r.rf_we && r.rf_addr != 0;
    if (d.pc != r.pc) c[0] = 1;
    if (dwe != rwe) c[1] = 1;
    else if (dwe && (d.rf_addr != r.rf_addr || d.rf_data != r.rf_data)) c[1] = 1;
    if (d.st_en != r.st_en) c[2] = 1;
    else if (d.st_en) begin
      if (d.st_addr != r.st_addr || d.st_be != r.st_be) c[2] = 1;
      for (int k = 0; k < 4; k++)
        if (d.st_be[k] && d.st_data[k*8 +: 8] != r.st_data[k*8 +: 8]) c[3] = 1;
    end
    return c;
  endfunction
  task automatic reset_all();
    @(negedge clk);
    rst = 1; dv = 0; rv = 0; clear = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    @(negedge clk);
  endtask
  task automatic push_pair(input rec_t d, input rec_t r);
    dr = d; rr = r; dv = 1; rv = 1;
    @(negedge clk);
    dv = 0; rv = 0;
    @(negedge clk);
  endtask
  task automatic test_reset();
    @(negedge clk);
    rst = 1;
    #1;
    tests++;
    if ({a_cv, a_mm, a_halt, a_code, a_mpc, a_mc, a_ec, a_dready, a_rready} !== '0) begin
      fails++; $display("FAIL reset_outputs got cv=%b mm=%b h=%b code=%b pc=%h mc=%0d ec=%0d rdy=%b%b want all 0",
        a_cv, a_mm, a_halt, a_code, a_mpc, a_mc, a_ec, a_dready, a_rready);
    end
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    tests++;
    if ({a_dready, a_rready, b_dready, b_rready} !== 4'b1111) begin
      fails++; $display("FAIL reset_ready got %b want 1111", {a_dready, a_rready, b_dready, b_rready});
    end
  endtask
  task automatic test_stream();
    rec_t recs[8];
    int di = 0, ri = 0, pulses = 0, mms = 0;
    reset_all();
    for (int i = 0; i < 8; i++) begin
      recs[i] = rand_rec();
      recs[i].pc = 32'(i * 4);
    end
    for (int cyc = 0; cyc < 80; cyc++) begin
      if (a_cv) pulses++;
      if (a_mm) mms++;
      dv = di < 8;
      if (dv) dr = recs[di];
      rv = ri < 8 && cyc >= 3;
      if (rv) rr = recs[ri];
      if (dv && a_dready) di++;
      if (rv && a_rready) ri++;
      @(negedge clk);
    end
    dv = 0; rv = 0;
    tests++;
    if (pulses != 8) begin fails++; $display("FAIL stream_pulses got %0d want 8", pulses); end
    tests++;
    if (mms != 0) begin fails++; $display("FAIL stream_mismatch got %0d want 0", mms); end
    tests++;
    if (a_mc !== 16'd8 || a_ec !== 16'd0) begin
      fails++; $display("FAIL stream_counts got match=%0d err=%0d want 8/0", a_mc, a_ec);
    end
  endtask
  task automatic test_store();
    rec_t d, r;
    reset_all();
    d = rand_rec(); d.st_en = 1; d.st_be = 4'b0010; r = d; r.st_data[7:0] ^= 8'h5A;
    push_pair(d, r);
    tests++;
    if (a_cv !== 1'b1 || a_mm !== 1'b0) begin
      fails++; $display("FAIL store_masked got cv=%b mm=%b want 1/0", a_cv, a_mm);
    end
    d = rand_rec(); d.st_en = 1; d.st_be = 4'b0010; r = d; r.st_data[15:8] ^= 8'h01;
    push_pair(d, r);
    tests++;
    if (a_cv !== 1'b1 || a_code !== 5'b01000) begin
      fails++; $display("FAIL store_data got cv=%b code=%b want 1/01000", a_cv, a_code);
    end
    tests++;
    if (a_mpc !== d.pc) begin fails++; $display("FAIL store_pc got %h want %h", a_mpc, d.pc); end
    @(negedge clk);
    tests++;
    if (a_halt !== 1'b1 || a_dready !== 1'b0 || a_cv !== 1'b0) begin
      fails++; $display("FAIL store_halt got halt=%b ready=%b cv=%b want 1/0/0", a_halt, a_dready, a_cv);
    end
  endtask
  task automatic test_rf();
    rec_t d, r;
    reset_all();
    d = rand_rec(); d.st_en = 0; r = d; d.rf_we = 1; d.rf_addr = 0; r.rf_we = 0;
    push_pair(d, r);
    tests++;
    if (a_cv !== 1'b1 || a_mm !== 1'b0 || a_code !== 5'b0) begin
      fails++; $display("FAIL rf_x0 got cv=%b mm=%b code=%b want 1/0/00000", a_cv, a_mm, a_code);
    end
    d.rf_we = 1; d.rf_addr = 5; d.rf_data = 32'h1; r = d; r.rf_data = 32'h2;
    push_pair(d, r);
    tests++;
    if (a_code !== 5'b00010 || b_code !== 5'b00010 || a_mm !== 1'b1) begin
      fails++; $display("FAIL rf_data got a=%b b=%b mm=%b want 00010/00010/1", a_code, b_code, a_mm);
    end
    tests++;
    if (b_halt !== 1'b0 || b_ec !== 16'd1 || b_mc !== 16'd1) begin
      fails++; $display("FAIL rf_cont got halt=%b err=%0d match=%0d want 0/1/1", b_halt, b_ec, b_mc);
    end
  endtask
  task automatic test_timeout();
    rec_t d;
    int k = 0;
    reset_all();
    d = rand_rec(); dr = d; dv = 1;
    @(negedge clk);
    dv = 0;
    while (!b_cv && k < 200) begin
      @(negedge clk);
      k++;
    end
    tests++;
    if (k != TMO) begin fails++; $display("FAIL timeout_latency got %0d want %0d", k, TMO); end
    tests++;
    if (b_code !== 5'b10000 || b_mm !== 1'b1 || b_ec !== 16'd1 || b_mpc !== d.pc) begin
      fails++; $display("FAIL timeout_result got code=%b mm=%b err=%0d pc=%h want 10000/1/1/%h",
        b_code, b_mm, b_ec, b_mpc, d.pc);
    end
    tests++;
    if (b_halt !== 1'b0 || a_halt !== 1'b1) begin
      fails++; $display("FAIL timeout_halt got b=%b a=%b want 0/1", b_halt, a_halt);
    end
    rr = d; rv = 1;
    @(negedge clk);
    rv = 0;
    @(negedge clk);
    tests++;
    if (b_cv !== 1'b1 || b_mm !== 1'b0 || b_mc !== 16'd1) begin
      fails++; $display("FAIL timeout_recover got cv=%b mm=%b match=%0d want 1/0/1", b_cv, b_mm, b_mc);
    end
  endtask
  task automatic test_clear();
    rec_t x;
    reset_all();
    x = rand_rec();
    push_pair(x, x);
    for (int i = 0; i < 4; i++) begin
      dr = rand_rec(); dv = 1;
      @(negedge clk);
    end
    dv = 0;
    tests++;
    if (a_dready !== 1'b0) begin fails++; $display("FAIL clear_full got ready=%b want 0", a_dready); end
    clear = 1; dv = 1; dr = rand_rec();
    @(negedge clk);
    clear = 0; dv = 0;
    tests++;
    if (a_dready !== 1'b1 || a_mc !== 16'd0 || a_ec !== 16'd0 || a_cv !== 1'b0) begin
      fails++; $display("FAIL clear_state got ready=%b match=%0d err=%0d cv=%b want 1/0/0/0",
        a_dready, a_mc, a_ec, a_cv);
    end
    x = rand_rec();
    push_pair(x, x);
    tests++;
    if (a_cv !== 1'b1 || a_mm !== 1'b0 || a_mc !== 16'd1) begin
      fails++; $display("FAIL clear_empty got cv=%b mm=%b match=%0d want 1/0/1", a_cv, a_mm, a_mc);
    end
  endtask
  task automatic test_rst_mid();
    rec_t x;
    int pulses = 0;
    reset_all();
    x = rand_rec();
    push_pair(x, x);
    for (int i = 0; i < 3; i++) begin
      dr = rand_rec(); dv = 1;
      @(negedge clk);
    end
    dv = 0;
    #2 rst = 1;
    #1;
    tests++;
    if ({a_cv, a_mm, a_halt, a_code, a_mpc, a_mc, a_ec, a_dready, a_rready,
         b_cv, b_mm, b_halt, b_code, b_mpc, b_mc, b_ec, b_dready, b_rready} !== '0) begin
      fails++; $display("FAIL rst_mid_outputs got a_mc=%0d a_pc=%h b_mc=%0d rdy=%b%b want all 0",
        a_mc, a_mpc, b_mc, a_dready, b_dready);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (a_cv || b_cv) pulses++;
    end
    tests++;
    if (pulses != 0) begin fails++; $display("FAIL rst_mid_pulses got %0d want 0", pulses); end
  endtask
  task automatic test_random();
    rec_t ds[N], rs[N], dq[$], rq[$], d, r;
    logic [4:0] e;
    int di = 0, ri = 0, seen = 0, cyc = 0, errs = 0;
    reset_all();
    for (int i = 0; i < N; i++) begin
      ds[i] = rand_rec();
      if ($urandom_range(0, 3) == 0) ds[i].rf_addr = 0;
      rs[i] = ds[i];
      case ($urandom_range(0, 7))
        0: rs[i].pc ^= 32'h4;
        1: rs[i].rf_data ^= 32'h1 << $urandom_range(0, 31);
        2: rs[i].rf_we = ~rs[i].rf_we;
        3: rs[i].st_data ^= $urandom;
        4: rs[i].st_be ^= 4'h1 << $urandom_range(0, 3);
        5: rs[i].st_en = ~rs[i].st_en;
        default: ;
      endcase
    end
    while (seen < N && cyc < 3000) begin
      if (b_cv) begin
        tests++;
        if (dq.size() == 0 || rq.size() == 0) begin
          fails++; $display("FAIL random_extra got pulse code=%b want none", b_code);
        end else begin
          d = dq.pop_front(); r = rq.pop_front(); e = exp_code(d, r);
          if (e != 0) errs++;
          seen++;
          if (b_code !== e || b_mm !== (e != 0)) begin
            fails++; $display("FAIL random_cmp #%0d got code=%b mm=%b want %b/%b", seen, b_code, b_mm, e, e != 0);
          end
        end
      end
      dv = di < N && $urandom_range(0, 3) != 0;
      if (dv) dr = ds[di];
      rv = ri < N && $urandom_range(0, 3) != 0;
      if (rv) rr = rs[ri];
      if (dv && b_dready) begin dq.push_back(ds[di]); di++; end
      if (rv && b_rready) begin rq.push_back(rs[ri]); ri++; end
      @(negedge clk);
      cyc++;
    end
    dv = 0; rv = 0;
    tests++;
    if (seen != N) begin fails++; $display("FAIL random_done got %0d want %0d", seen, N); end
    tests++;
    if (b_ec !== 16'(errs) || b_mc !== 16'(N - errs)) begin
      fails++; $display("FAIL random_counts got match=%0d err=%0d want %0d/%0d", b_mc, b_ec, N - errs, errs);
    end
  endtask
  initial begin
    test_reset();
    test_stream();
    test_store();
    test_rf();
    test_timeout();
    test_clear();
    test_rst_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
endmodule
